// File: rtl/tsip_pkg.sv
// Shared constants for the TSIP timing decoder: framing bytes, framing FSM encoding and
// the byte offsets of the Primary Timing (0x8F-AB) fields in the de-stuffed payload.
package tsip_pkg;

    localparam logic [7:0] DLE = 8'h10;
    localparam logic [7:0] ETX = 8'h03;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ID   = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ESC  = 2'd3;

    localparam int unsigned IDX_SUBCODE    = 0;
    localparam int unsigned IDX_TOW        = 1;
    localparam int unsigned IDX_WEEK       = 5;
    localparam int unsigned IDX_UTC_OFFSET = 7;
    localparam int unsigned IDX_FLAG       = 9;
    localparam int unsigned IDX_SECONDS    = 10;
    localparam int unsigned IDX_MINUTES    = 11;
    localparam int unsigned IDX_HOUR       = 12;
    localparam int unsigned IDX_DAY        = 13;
    localparam int unsigned IDX_MONTH      = 14;
    localparam int unsigned IDX_YEAR       = 15;

    localparam int unsigned SHADOW_LEN = IDX_YEAR + 2;

endpackage

// File: rtl/tsip_destuffer.sv
// TSIP framing FSM: strips DLE framing/stuffing and reports packet start, payload bytes,
// clean end (DLE-ETX) and abort (bad escape or mid-packet inactivity timeout).
module tsip_destuffer
    import tsip_pkg::*;
#(
    parameter int unsigned C_TIMEOUT_CLKS = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_start,
    output logic [7:0] o_id,
    output logic       o_data_dv,
    output logic [7:0] o_data,
    output logic       o_end,
    output logic       o_abort
);

    localparam logic [31:0] TMO_LAST = 32'(C_TIMEOUT_CLKS - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_expired;

    assign tmo_expired = (state_q != ST_IDLE) && (tmo_q >= TMO_LAST);

    always_comb begin
        state_d   = state_q;
        o_start   = 1'b0;
        o_id      = i_rx_byte;
        o_data_dv = 1'b0;
        o_data    = i_rx_byte;
        o_end     = 1'b0;
        o_abort   = 1'b0;

        // An arriving byte takes priority over a timeout expiring in the same cycle.
        if (i_rx_dv) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_byte == DLE) state_d = ST_ID;
                end
                ST_ID: begin
                    if (i_rx_byte == DLE || i_rx_byte == ETX) begin
                        state_d = ST_IDLE;
                    end else begin
                        o_start = 1'b1;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_rx_byte == DLE) state_d = ST_ESC;
                    else                  o_data_dv = 1'b1;
                end
                ST_ESC: begin
                    if (i_rx_byte == DLE) begin
                        o_data_dv = 1'b1;
                        state_d   = ST_DATA;
                    end else if (i_rx_byte == ETX) begin
                        o_end   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Unexpected escape: drop current packet, reuse byte as next ID.
                        o_abort = 1'b1;
                        o_start = 1'b1;
                        state_d = ST_DATA;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_expired) begin
            o_abort = 1'b1;
            state_d = ST_IDLE;
        end

        if (i_rx_dv || state_q == ST_IDLE || tmo_expired) tmo_d = '0;
        else                                               tmo_d = tmo_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/tsip_timing_decoder.sv
// Decodes the Thunderbolt TSIP Primary Timing packet into registered UTC/GPS fields with a
// one-cycle valid strobe, and flags malformed or aborted timing packets.
module tsip_timing_decoder
    import tsip_pkg::*;
#(
    parameter logic [7:0]  C_PACKET_ID    = 8'h8F,
    parameter logic [7:0]  C_SUBCODE      = 8'hAB,
    parameter int unsigned C_PAYLOAD_LEN  = 17,
    parameter int unsigned C_TIMEOUT_CLKS = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic        o_thunder_packet_dv,
    output logic [31:0] o_thunder_tow,
    output logic [15:0] o_thunder_week,
    output logic [15:0] o_thunder_utc_offset,
    output logic [7:0]  o_thunder_timing_flag,
    output logic [7:0]  o_thunder_seconds,
    output logic [7:0]  o_thunder_minutes,
    output logic [7:0]  o_thunder_hour,
    output logic [7:0]  o_thunder_day,
    output logic [7:0]  o_thunder_month,
    output logic [15:0] o_thunder_year,
    output logic        o_frame_err
);

    localparam logic [4:0] PAYLOAD_LEN_W = 5'(C_PAYLOAD_LEN);
    localparam logic [4:0] SHADOW_LEN_W  = 5'(SHADOW_LEN);
    localparam logic [4:0] COUNT_MAX     = 5'd31;

    logic       start, data_dv, pkt_end, abort;
    logic [7:0] id, data;

    tsip_destuffer #(
        .C_TIMEOUT_CLKS(C_TIMEOUT_CLKS)
    ) u_destuffer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rx_dv  (i_rx_dv),
        .i_rx_byte(i_rx_byte),
        .o_start  (start),
        .o_id     (id),
        .o_data_dv(data_dv),
        .o_data   (data),
        .o_end    (pkt_end),
        .o_abort  (abort)
    );

    logic        match_q, match_d;
    logic [4:0]  count_q, count_d;
    logic [7:0]  shadow_q [SHADOW_LEN];
    logic        target, pkt_ok, err_d;
    logic        dv_q, err_q;
    logic [31:0] tow_q;
    logic [15:0] week_q, utc_q, year_q;
    logic [7:0]  flag_q, sec_q, min_q, hour_q, day_q, month_q;

    always_comb begin
        match_d = match_q;
        count_d = count_q;
        if (start) begin
            match_d = (id == C_PACKET_ID);
            count_d = '0;
        end else if (pkt_end || abort) begin
            match_d = 1'b0;
        end
        if (data_dv && count_q != COUNT_MAX) count_d = count_q + 5'd1;

        // Other 0x8F subcodes are legitimate traffic, so only our subcode can raise an error.
        target = match_q && (count_q == 5'd0 || shadow_q[IDX_SUBCODE] == C_SUBCODE);
        pkt_ok = pkt_end && match_q && (count_q == PAYLOAD_LEN_W)
                 && (shadow_q[IDX_SUBCODE] == C_SUBCODE);
        err_d  = target && ((pkt_end && !pkt_ok) || abort);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            match_q <= 1'b0;
            count_q <= '0;
            for (int unsigned i = 0; i < SHADOW_LEN; i++) shadow_q[i] <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            tow_q   <= '0;
            week_q  <= '0;
            utc_q   <= '0;
            flag_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= '0;
            month_q <= '0;
            year_q  <= '0;
        end else begin
            match_q <= match_d;
            count_q <= count_d;
            dv_q    <= pkt_ok;
            err_q   <= err_d;
            if (data_dv && count_q < SHADOW_LEN_W) shadow_q[count_q] <= data;
            if (pkt_ok) begin
                tow_q   <= {shadow_q[IDX_TOW], shadow_q[IDX_TOW+1],
                            shadow_q[IDX_TOW+2], shadow_q[IDX_TOW+3]};
                week_q  <= {shadow_q[IDX_WEEK], shadow_q[IDX_WEEK+1]};
                utc_q   <= {shadow_q[IDX_UTC_OFFSET], shadow_q[IDX_UTC_OFFSET+1]};
                flag_q  <= shadow_q[IDX_FLAG];
                sec_q   <= shadow_q[IDX_SECONDS];
                min_q   <= shadow_q[IDX_MINUTES];
                hour_q  <= shadow_q[IDX_HOUR];
                day_q   <= shadow_q[IDX_DAY];
                month_q <= shadow_q[IDX_MONTH];
                year_q  <= {shadow_q[IDX_YEAR], shadow_q[IDX_YEAR+1]};
            end
        end
    end

    assign o_thunder_packet_dv   = dv_q;
    assign o_frame_err           = err_q;
    assign o_thunder_tow         = tow_q;
    assign o_thunder_week        = week_q;
    assign o_thunder_utc_offset  = utc_q;
    assign o_thunder_timing_flag = flag_q;
    assign o_thunder_seconds     = sec_q;
    assign o_thunder_minutes     = min_q;
    assign o_thunder_hour        = hour_q;
    assign o_thunder_day         = day_q;
    assign o_thunder_month       = month_q;
    assign o_thunder_year        = year_q;

endmodule

// File: tb/tb_tsip_timing_decoder.sv
// Self-checking bench: builds TSIP frames from field records and checks the decoder against
// the packet-level outcome (publish / error / ignore) each frame should produce.
module tb_tsip_timing_decoder;

    localparam int unsigned TMO = 300;

    typedef struct packed {
        logic [31:0] tow;
        logic [15:0] week;
        logic [15:0] utc;
        logic [7:0]  flag;
        logic [7:0]  sec;
        logic [7:0]  min;
        logic [7:0]  hour;
        logic [7:0]  day;
        logic [7:0]  month;
        logic [15:0] year;
    } fields_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        dv, err;
    logic [31:0] tow;
    logic [15:0] week, utc, year;
    logic [7:0]  flag, sec, min, hour, day, month;

    always #5 clk = ~clk;

    tsip_timing_decoder #(
        .C_TIMEOUT_CLKS(TMO)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_rx_dv              (rx_dv),
        .i_rx_byte            (rx_byte),
        .o_thunder_packet_dv  (dv),
        .o_thunder_tow        (tow),
        .o_thunder_week       (week),
        .o_thunder_utc_offset (utc),
        .o_thunder_timing_flag(flag),
        .o_thunder_seconds    (sec),
        .o_thunder_minutes    (min),
        .o_thunder_hour       (hour),
        .o_thunder_day        (day),
        .o_thunder_month      (month),
        .o_thunder_year       (year),
        .o_frame_err          (err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int dv_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (dv === 1'b1)  dv_cnt  <= dv_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
    end

    fields_t    exp_f;
    logic [7:0] pay_q[$];
    logic       dv_at_lat;

    function automatic logic [7:0] rbyte();
        return ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.tow   = {rbyte(), rbyte(), rbyte(), rbyte()};
        f.week  = {rbyte(), rbyte()};
        f.utc   = {rbyte(), rbyte()};
        f.flag  = rbyte();
        f.sec   = rbyte();
        f.min   = rbyte();
        f.hour  = rbyte();
        f.day   = rbyte();
        f.month = rbyte();
        f.year  = {rbyte(), rbyte()};
        return f;
    endfunction

    function automatic int pick_gap(input bit gaps);
        return gaps ? int'($urandom_range(0, 2)) : 0;
    endfunction

    task automatic make_payload(input fields_t f, input logic [7:0] sub);
        pay_q.delete();
        pay_q.push_back(sub);
        pay_q.push_back(f.tow[31:24]);
        pay_q.push_back(f.tow[23:16]);
        pay_q.push_back(f.tow[15:8]);
        pay_q.push_back(f.tow[7:0]);
        pay_q.push_back(f.week[15:8]);
        pay_q.push_back(f.week[7:0]);
        pay_q.push_back(f.utc[15:8]);
        pay_q.push_back(f.utc[7:0]);
        pay_q.push_back(f.flag);
        pay_q.push_back(f.sec);
        pay_q.push_back(f.min);
        pay_q.push_back(f.hour);
        pay_q.push_back(f.day);
        pay_q.push_back(f.month);
        pay_q.push_back(f.year[15:8]);
        pay_q.push_back(f.year[7:0]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_dv = 1'b0;
        end
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
    endtask

    // Frames pay_q with DLE-stuffing; samples dv on the first cycle after the ETX strobe.
    task automatic send_frame(input logic [7:0] id, input bit gaps);
        send_byte(8'h10, pick_gap(gaps));
        send_byte(id, pick_gap(gaps));
        foreach (pay_q[i]) begin
            send_byte(pay_q[i], pick_gap(gaps));
            if (pay_q[i] == 8'h10) send_byte(8'h10, 0);
        end
        send_byte(8'h10, pick_gap(gaps));
        send_byte(8'h03, 0);
        @(negedge clk);
        rx_dv     = 1'b0;
        dv_at_lat = dv;
    endtask

    task automatic check_fields(input string tag);
        check({tag, ".tow"},   tow,   exp_f.tow);
        check({tag, ".week"},  week,  exp_f.week);
        check({tag, ".utc"},   utc,   exp_f.utc);
        check({tag, ".flag"},  flag,  exp_f.flag);
        check({tag, ".sec"},   sec,   exp_f.sec);
        check({tag, ".min"},   min,   exp_f.min);
        check({tag, ".hour"},  hour,  exp_f.hour);
        check({tag, ".day"},   day,   exp_f.day);
        check({tag, ".month"}, month, exp_f.month);
        check({tag, ".year"},  year,  exp_f.year);
    endtask

    task automatic run_packet(input string tag, input logic [7:0] id, input bit gaps,
                              input int exp_dv, input int exp_err, input fields_t f);
        int d0, e0;
        d0 = dv_cnt;
        e0 = err_cnt;
        send_frame(id, gaps);
        if (exp_dv != 0) check({tag, ".dv_latency"}, dv_at_lat, 1);
        repeat (3) @(negedge clk);
        check({tag, ".dv_pulses"}, dv_cnt - d0, exp_dv);
        check({tag, ".err_pulses"}, err_cnt - e0, exp_err);
        if (exp_dv != 0) exp_f = f;
        check_fields(tag);
    endtask

    fields_t f1, f2, fr;
    logic [7:0] id_r, sub_r;
    int d0, e0, kind, len;

    initial begin
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        exp_f   = '0;
        repeat (3) @(negedge clk);
        check("reset.dv", dv, 0);
        check("reset.err", err, 0);
        check_fields("reset");
        rst = 1'b0;

        f1 = '{tow: 32'h00054321, week: 16'd2305, utc: 16'd18, flag: 8'h03, sec: 8'd56,
               min: 8'd34, hour: 8'd12, day: 8'd15, month: 8'd3, year: 16'd2024};
        make_payload(f1, 8'hAB);
        run_packet("valid", 8'h8F, 1'b0, 1, 0, f1);

        f2     = f1;
        f2.sec = 8'h10;
        make_payload(f2, 8'hAB);
        run_packet("stuffed_sec", 8'h8F, 1'b0, 1, 0, f2);

        fr     = f1;
        fr.tow = 32'h12104455;
        make_payload(fr, 8'hAC);
        run_packet("subcode_ac", 8'h8F, 1'b0, 0, 0, fr);

        make_payload(f1, 8'hAB);
        void'(pay_q.pop_back());
        run_packet("truncated", 8'h8F, 1'b0, 0, 1, f1);

        // Timeout mid-packet.
        d0 = dv_cnt;
        e0 = err_cnt;
        send_byte(8'h10, 0);
        send_byte(8'h8F, 0);
        send_byte(8'hAB, 0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (TMO - 5) @(negedge clk);
        check("timeout.early_err", err_cnt - e0, 0);
        repeat (15) @(negedge clk);
        check("timeout.err_pulses", err_cnt - e0, 1);
        check("timeout.dv_pulses", dv_cnt - d0, 0);
        fr = rand_fields();
        make_payload(fr, 8'hAB);
        run_packet("after_timeout", 8'h8F, 1'b1, 1, 0, fr);

        // Reset mid-packet; f1 carries no 0x10 bytes so the leftover tail cannot reframe.
        make_payload(f1, 8'hAB);
        send_byte(8'h10, 0);
        send_byte(8'h8F, 0);
        for (int i = 0; i < 8; i++) send_byte(pay_q[i], 0);
        @(negedge clk);
        rx_dv = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        exp_f = '0;
        check("rst_mid.dv", dv, 0);
        check_fields("rst_mid");
        d0 = dv_cnt;
        e0 = err_cnt;
        for (int i = 8; i < 17; i++) send_byte(pay_q[i], 0);
        send_byte(8'h10, 0);
        send_byte(8'h03, 0);
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tail.dv_pulses", dv_cnt - d0, 0);
        check("rst_tail.err_pulses", err_cnt - e0, 0);
        check_fields("rst_tail");
        fr = rand_fields();
        make_payload(fr, 8'hAB);
        run_packet("after_reset", 8'h8F, 1'b1, 1, 0, fr);

        for (int n = 0; n < 30; n++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                id_r = 8'($urandom);
                if (id_r == 8'h10) id_r = 8'h55;
                send_byte(id_r, pick_gap(1'b1));
            end
            kind = int'($urandom_range(0, 4));
            fr   = rand_fields();
            case (kind)
                0: begin
                    make_payload(fr, 8'hAB);
                    run_packet("rnd_valid", 8'h8F, 1'b1, 1, 0, fr);
                end
                1: begin
                    do id_r = 8'($urandom);
                    while (id_r == 8'h10 || id_r == 8'h03 || id_r == 8'h8F);
                    make_payload(fr, 8'hAB);
                    run_packet("rnd_other_id", id_r, 1'b1, 0, 0, fr);
                end
                2: begin
                    do sub_r = rbyte();
                    while (sub_r == 8'hAB);
                    make_payload(fr, sub_r);
                    run_packet("rnd_other_sub", 8'h8F, 1'b1, 0, 0, fr);
                end
                3: begin
                    make_payload(fr, 8'hAB);
                    len = int'($urandom_range(0, 16));
                    while (pay_q.size() > len) void'(pay_q.pop_back());
                    run_packet("rnd_short", 8'h8F, 1'b1, 0, 1, fr);
                end
                default: begin
                    make_payload(fr, 8'hAB);
                    for (int j = $urandom_range(1, 15); j > 0; j--) pay_q.push_back(rbyte());
                    run_packet("rnd_long", 8'h8F, 1'b1, 0, 1, fr);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
